multi_zone_alarm_ctrl: RTL and testbench

//   Parametrised multi-zone alarm controller; next generation of the single-sensor OFF/ARMED/TRIGGERED/ALARM_ON FSM.

---
 rtl/alarm_pkg.sv | 13 +
 rtl/alarm_down_counter.sv | 28 ++
 rtl/multi_zone_alarm_ctrl.sv | 133 +++++++++++++
 tb/tb_multi_zone_alarm_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared state encoding for the multi-zone alarm controller.
package alarm_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        OFF       = 2'b00,
        ARMED     = 2'b01,
        TRIGGERED = 2'b10,
        ALARM_ON  = 2'b11
    } alarm_state_t;

endpackage

// File: rtl/alarm_down_counter.sv
// Loadable down-counter that stops at zero and holds while en is low.
module alarm_down_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            if (load) begin
                count <= value;
            end else if (count != '0) begin
                count <= count - 1'b1;
            end
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/multi_zone_alarm_ctrl.sv
// Multi-zone alarm FSM with entry delay, siren timeout and tripped-zone latch.
// Define ALARM_BYPASS_EN to add the per-zone bypass mask input.
module multi_zone_alarm_ctrl
    import alarm_pkg::*;
#(
    parameter  int NUM_ZONES    = 4,
    parameter  int ENTRY_DELAY  = 16,
    parameter  int ALARM_CYCLES = 64,
    localparam int MAX_CNT      = (ENTRY_DELAY > ALARM_CYCLES) ? ENTRY_DELAY : ALARM_CYCLES,
    localparam int CNT_W        = $clog2(MAX_CNT + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic                 arm,
    input  logic                 disarm,
    input  logic [NUM_ZONES-1:0] sensor,
`ifdef ALARM_BYPASS_EN
    input  logic [NUM_ZONES-1:0] bypass,
`endif
    output logic [STATE_W-1:0]   state,
    output logic                 alarm,
    output logic                 arm_fault,
    output logic [NUM_ZONES-1:0] zone_latched,
    output logic [CNT_W-1:0]     countdown
);

    alarm_state_t         state_q;
    alarm_state_t         next_state;
    logic [NUM_ZONES-1:0] active;
    logic                 any_active;
    logic                 cnt_load;
    logic [CNT_W-1:0]     cnt_value;
    logic [CNT_W-1:0]     cnt;
    logic                 cnt_zero;
    logic                 latch_clr;
    logic [NUM_ZONES-1:0] latch_set;
    logic                 fault_set;
    logic                 fault_q;

`ifdef ALARM_BYPASS_EN
    assign active = sensor & ~bypass;
`else
    assign active = sensor;
`endif
    assign any_active = |active;

    alarm_down_counter #(.W(CNT_W)) u_counter (
        .clk   (clk),
        .rst   (rst),
        .en    (ena),
        .load  (cnt_load),
        .value (cnt_value),
        .count (cnt),
        .zero  (cnt_zero)
    );

    always_comb begin
        next_state = state_q;
        cnt_load   = 1'b0;
        cnt_value  = '0;
        latch_clr  = 1'b0;
        latch_set  = '0;
        fault_set  = 1'b0;
        if (disarm) begin
            next_state = OFF;
            cnt_load   = 1'b1;
            latch_clr  = 1'b1;
        end else begin
            case (state_q)
                OFF: begin
                    if (arm) begin
                        if (any_active) begin
                            fault_set = 1'b1;
                        end else begin
                            next_state = ARMED;
                            latch_clr  = 1'b1;
                        end
                    end
                end
                ARMED: begin
                    latch_set = active;
                    if (any_active) begin
                        next_state = TRIGGERED;
                        cnt_load   = 1'b1;
                        cnt_value  = CNT_W'(ENTRY_DELAY - 1);
                    end
                end
                TRIGGERED: begin
                    latch_set = active;
                    if (cnt_zero) begin
                        next_state = ALARM_ON;
                        cnt_load   = 1'b1;
                        cnt_value  = CNT_W'(ALARM_CYCLES - 1);
                    end
                end
                ALARM_ON: begin
                    // Fresh sensor activity only latches; the siren timeout keeps running.
                    latch_set = active;
                    if (cnt_zero) begin
                        next_state = ARMED;
                        cnt_load   = 1'b1;
                    end
                end
                default: next_state = OFF;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= OFF;
            zone_latched <= '0;
            fault_q      <= 1'b0;
        end else begin
            fault_q <= ena & fault_set;
            if (ena) begin
                state_q <= next_state;
                if (latch_clr) begin
                    zone_latched <= '0;
                end else begin
                    zone_latched <= zone_latched | latch_set;
                end
            end
        end
    end

    assign state     = state_q;
    assign alarm     = (state_q == ALARM_ON);
    assign arm_fault = fault_q;
    assign countdown = (state_q == TRIGGERED || state_q == ALARM_ON) ? cnt : '0;

endmodule

// File: tb/tb_multi_zone_alarm_ctrl.sv
// Directed bench for multi_zone_alarm_ctrl with an expected-value queue.
module tb_multi_zone_alarm_ctrl;

    logic       clk;
    logic       rst;
    logic       ena;
    logic       arm;
    logic       disarm;
    logic [3:0] sensor;
`ifdef ALARM_BYPASS_EN
    logic [3:0] bypass;
`endif
    logic [1:0] state;
    logic       alarm;
    logic       arm_fault;
    logic [3:0] zone_latched;
    logic [6:0] countdown;

    typedef struct {
        string      tag;
        logic [1:0] st;
        logic       al;
        logic [3:0] lz;
        logic [6:0] cd;
        logic       af;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    multi_zone_alarm_ctrl #(
        .NUM_ZONES   (4),
        .ENTRY_DELAY (16),
        .ALARM_CYCLES(64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .arm         (arm),
        .disarm      (disarm),
        .sensor      (sensor),
`ifdef ALARM_BYPASS_EN
        .bypass      (bypass),
`endif
        .state       (state),
        .alarm       (alarm),
        .arm_fault   (arm_fault),
        .zone_latched(zone_latched),
        .countdown   (countdown)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input string field, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [1:0] st, input logic al,
                        input logic [3:0] lz, input logic [6:0] cd, input logic af);
        exp_t e;
        e.tag = tag; e.st = st; e.al = al; e.lz = lz; e.cd = cd; e.af = af;
        q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = q.pop_front();
        chk(e.tag, "state", 32'(state), 32'(e.st));
        chk(e.tag, "alarm", 32'(alarm), 32'(e.al));
        chk(e.tag, "zone_latched", 32'(zone_latched), 32'(e.lz));
        chk(e.tag, "countdown", 32'(countdown), 32'(e.cd));
        chk(e.tag, "arm_fault", 32'(arm_fault), 32'(e.af));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        pop_check();
    endtask

    initial begin
        ena = 1'b1; arm = 1'b0; disarm = 1'b0; sensor = 4'b0000;
`ifdef ALARM_BYPASS_EN
        bypass = 4'b0000;
`endif
        rst = 1'b1;
        #3;
        push("reset", 2'b00, 0, 4'b0000, 0, 0);
        pop_check();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // arm, trip zone 2, run entry delay
        arm = 1'b1;
        push("arm", 2'b01, 0, 4'b0000, 0, 0); tick();
        arm = 1'b0; sensor = 4'b0100;
        push("trip", 2'b10, 0, 4'b0100, 15, 0); tick();
        sensor = 4'b0000;
        for (int i = 1; i <= 15; i++) begin
            push("entry", 2'b10, 0, 4'b0100, 7'(15 - i), 0); tick();
        end
        push("siren_on", 2'b11, 1, 4'b0100, 63, 0); tick();

        // siren timeout, with sensor[1] activity mid-alarm
        for (int i = 1; i <= 63; i++) begin
            if (i == 5) sensor = 4'b0010;
            push("siren", 2'b11, 1, (i >= 5) ? 4'b0110 : 4'b0100, 7'(63 - i), 0); tick();
            sensor = 4'b0000;
        end
        push("rearm", 2'b01, 0, 4'b0110, 0, 0); tick();

        // retrigger then disarm at countdown 5
        sensor = 4'b1000;
        push("retrip", 2'b10, 0, 4'b1110, 15, 0); tick();
        sensor = 4'b0000;
        for (int i = 1; i <= 10; i++) begin
            push("entry2", 2'b10, 0, 4'b1110, 7'(15 - i), 0); tick();
        end
        disarm = 1'b1;
        push("disarm", 2'b00, 0, 4'b0000, 0, 0); tick();
        disarm = 1'b0;

        // arm refused with active zone, arm+disarm together
        sensor = 4'b0001; arm = 1'b1;
        push("arm_fault", 2'b00, 0, 4'b0000, 0, 1); tick();
        sensor = 4'b0000; arm = 1'b0;
        push("fault_pulse", 2'b00, 0, 4'b0000, 0, 0); tick();
        sensor = 4'b0001; arm = 1'b1; disarm = 1'b1;
        push("arm_disarm", 2'b00, 0, 4'b0000, 0, 0); tick();
        sensor = 4'b0000; disarm = 1'b0;
        push("arm2", 2'b01, 0, 4'b0000, 0, 0); tick();
        arm = 1'b0; sensor = 4'b0001;
        push("trip2", 2'b10, 0, 4'b0001, 15, 0); tick();
        sensor = 4'b0000;
        push("dec14", 2'b10, 0, 4'b0001, 14, 0); tick();
        push("dec13", 2'b10, 0, 4'b0001, 13, 0); tick();

        // ena low freezes everything, even disarm and new sensors
        ena = 1'b0; disarm = 1'b1; sensor = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            push("frozen", 2'b10, 0, 4'b0001, 13, 0); tick();
        end
        ena = 1'b1; disarm = 1'b0; sensor = 4'b0000;
        push("thaw", 2'b10, 0, 4'b0001, 12, 0); tick();
        disarm = 1'b1;
        push("disarm2", 2'b00, 0, 4'b0000, 0, 0); tick();
        disarm = 1'b0;

`ifdef ALARM_BYPASS_EN
        bypass = 4'b0001; sensor = 4'b0001; arm = 1'b1;
        push("byp_arm", 2'b01, 0, 4'b0000, 0, 0); tick();
        arm = 1'b0;
        push("byp_hold", 2'b01, 0, 4'b0000, 0, 0); tick();
        push("byp_hold2", 2'b01, 0, 4'b0000, 0, 0); tick();
        sensor = 4'b0011;
        push("byp_trip", 2'b10, 0, 4'b0010, 15, 0); tick();
        sensor = 4'b0000; bypass = 4'b0000;
        push("byp_dec", 2'b10, 0, 4'b0010, 14, 0); tick();
`else
        arm = 1'b1;
        push("arm3", 2'b01, 0, 4'b0000, 0, 0); tick();
        arm = 1'b0; sensor = 4'b0010;
        push("trip3", 2'b10, 0, 4'b0010, 15, 0); tick();
        sensor = 4'b0000;
        push("dec3", 2'b10, 0, 4'b0010, 14, 0); tick();
`endif

        // asynchronous reset mid-TRIGGERED, checked before any clock edge
        #2;
        rst = 1'b1;
        #1;
        push("async_rst", 2'b00, 0, 4'b0000, 0, 0);
        pop_check();
        @(negedge clk);
        rst = 1'b0;
        push("post_rst", 2'b00, 0, 4'b0000, 0, 0); tick();

        chk("scoreboard", "leftover", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
